// File: rtl/conv_code_pkg.sv
// Shared constants, FSM state type and branch-output helper for the
// K=3, rate-1/2 convolutional code (G0=7, G1=5 octal). The Viterbi decoder
// branch metric units use the same constants.
package conv_code_pkg;

    localparam int         CONV_K      = 3;
    localparam logic [2:0] CONV_G0     = 3'b111;
    localparam logic [2:0] CONV_G1     = 3'b101;
    localparam int         CONV_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_HOLD   = 2'd2
    } conv_state_t;

    // Coded bit pair {c0,c1} for input bit u leaving trellis state {s1,s0}.
    function automatic logic [1:0] conv_branch(input logic u, input logic s1, input logic s0);
        logic [2:0] taps;
        taps = {u, s1, s0};
        return {^(CONV_G0 & taps), ^(CONV_G1 & taps)};
    endfunction

endpackage

// File: rtl/conv_branch_out.sv
// Combinational branch output of the convolutional code:
// {u,s1,s0} -> {c0,c1}, with c0 from generator G0 and c1 from G1.
module conv_branch_out
    import conv_code_pkg::*;
#(
    parameter logic [2:0] G0 = CONV_G0,
    parameter logic [2:0] G1 = CONV_G1
) (
    input  logic       i_u,
    input  logic       i_s1,
    input  logic       i_s0,
    output logic [1:0] o_pair
);

    logic [2:0] w_taps;

    // Parity of the tapped register bits for each generator.
    always_comb begin
        w_taps = {i_u, i_s1, i_s0};
        o_pair = {^(G0 & w_taps), ^(G1 & w_taps)};
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder. One DATA_W-bit message per
// transaction is encoded MSB first from trellis state 00; the codeword is
// presented with the first coded pair in the top two bits.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on that side; valid_out stays high with data_out stable until
// ready_in is seen, and ready_out is only high in IDLE.
//
// Optional feature macro: CONV_ENCODER_ERR_INJECT_EN adds port err_mask,
// captured with data_in and XORed into the codeword as it enters HOLD.
module conv_encoder
    import conv_code_pkg::*;
#(
    parameter int         DATA_W = CONV_DATA_W,
    parameter logic [2:0] G0     = CONV_G0,
    parameter logic [2:0] G1     = CONV_G1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [DATA_W-1:0]     data_in,
`ifdef CONV_ENCODER_ERR_INJECT_EN
    input  logic [2*DATA_W-1:0]   err_mask,
`endif
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [2*DATA_W-1:0]   data_out,
    output logic                  busy
);

    localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    conv_state_t          r_state;
    conv_state_t          w_next;
    logic [DATA_W-1:0]    r_msg;
    logic [1:0]           r_trellis;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*DATA_W-1:0]  r_code;
    logic [1:0]           w_pair;
    logic                 w_accept;
    logic                 w_last;
`ifdef CONV_ENCODER_ERR_INJECT_EN
    logic [2*DATA_W-1:0]  r_mask;
`endif

    assign w_accept = (r_state == ST_IDLE) && valid_in;
    assign w_last   = (r_state == ST_ENCODE) && (r_cnt == LAST);
    assign data_out = r_code;

    conv_branch_out #(
        .G0 (G0),
        .G1 (G1)
    ) u_branch (
        .i_u    (r_msg[DATA_W-1]),
        .i_s1   (r_trellis[1]),
        .i_s0   (r_trellis[0]),
        .o_pair (w_pair)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        w_next    = r_state;
        ready_out = 1'b0;
        valid_out = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready_out = 1'b1;
                if (valid_in) w_next = ST_ENCODE;
            end
            ST_ENCODE: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = ST_HOLD;
            end
            ST_HOLD: begin
                busy      = 1'b1;
                valid_out = 1'b1;
                if (ready_in) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Message capture and bit-serial encoding datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_msg     <= '0;
            r_trellis <= 2'b00;
            r_cnt     <= '0;
            r_code    <= '0;
`ifdef CONV_ENCODER_ERR_INJECT_EN
            r_mask    <= '0;
`endif
        end else if (w_accept) begin
            r_msg     <= data_in;
            r_trellis <= 2'b00;
            r_cnt     <= '0;
`ifdef CONV_ENCODER_ERR_INJECT_EN
            r_mask    <= err_mask;
`endif
        end else if (r_state == ST_ENCODE) begin
`ifdef CONV_ENCODER_ERR_INJECT_EN
            r_code    <= {r_code[2*DATA_W-3:0], w_pair} ^ (w_last ? r_mask : '0);
`else
            r_code    <= {r_code[2*DATA_W-3:0], w_pair};
`endif
            r_msg     <= {r_msg[DATA_W-2:0], 1'b0};
            r_trellis <= {r_msg[DATA_W-1], r_trellis[1]};
            r_cnt     <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed testbench for conv_encoder (DATA_W=8, G0=7, G1=5).
// Expected codewords are hand-derived from the trellis.
module tb_conv_encoder;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_in;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] data_out;
    logic        busy;
`ifdef CONV_ENCODER_ERR_INJECT_EN
    logic [15:0] err_mask;
`endif

    int checks = 0;
    int errors = 0;

    conv_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (data_in),
`ifdef CONV_ENCODER_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .busy      (busy)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts edges after the accept edge until valid_out, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (valid_out !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; data_in = 8'h00;
`ifdef CONV_ENCODER_ERR_INJECT_EN
        err_mask = 16'h0000;
`endif
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b dout=%h, want 1 0 0 0000", ready_out, valid_out, busy, data_out);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b, want 1 0", ready_out, busy);
        end
    endtask

    // Encode one message with an immediate downstream accept.
    task automatic test_encode(input logic [7:0] d, input logic [15:0] exp, input string name);
        int cyc;
        valid_in = 1'b1; data_in = d; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = 8'h00;
        checks++;
        if (busy !== 1'b1 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: busy=%b rdy=%b, want 1 0", name, busy, ready_out);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want 8", name, cyc);
        end
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h, want %h", name, data_out, exp);
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0 || data_out !== exp) begin
            errors++;
            $display("FAIL %s_done: vld=%b rdy=%b busy=%b dout=%h, want 0 1 0 %h",
                     name, valid_out, ready_out, busy, data_out, exp);
        end
    endtask

    // Stall the output for 5 cycles while extra valid_in pulses are ignored.
    task automatic test_hold_stall();
        int cyc;
        int bad_rdy;
        valid_in = 1'b1; data_in = 8'hB0; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = 8'h00;
        @(posedge clk); #1;
        valid_in = 1'b1; data_in = 8'h55;
        bad_rdy = 0;
        cyc = 1;
        while (valid_out !== 1'b1 && cyc < 20) begin
            if (ready_out !== 1'b0) bad_rdy++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles, want 8", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            if (ready_out !== 1'b0) bad_rdy++;
            checks++;
            if (valid_out !== 1'b1 || data_out !== 16'hE170) begin
                errors++;
                $display("FAIL stall_hold%0d: vld=%b dout=%h, want 1 e170", i, valid_out, data_out);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bad_rdy !== 0) begin
            errors++;
            $display("FAIL stall_ready_low: ready_out high in %0d busy cycles, want 0", bad_rdy);
        end
        valid_in = 1'b0; data_in = 8'h00;
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 16'hE170) begin
            errors++;
            $display("FAIL stall_release: busy=%b vld=%b dout=%h, want 0 0 e170", busy, valid_out, data_out);
        end
    endtask

    // Two messages with valid_in held high and ready_in always high.
    task automatic test_back_to_back();
        int cyc;
        valid_in = 1'b1; data_in = 8'hB0; ready_in = 1'b1;
        @(posedge clk); #1;
        data_in = 8'h80;
        wait_valid(cyc);
        checks++;
        if (cyc !== 8 || data_out !== 16'hE170) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d dout=%h, want 8 e170", cyc, data_out);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: vld=%b rdy=%b busy=%b, want 0 1 0", valid_out, ready_out, busy);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = 8'h00;
        checks++;
        if (busy !== 1'b1 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b rdy=%b, want 1 0", busy, ready_out);
        end
        wait_valid(cyc);
        checks++;
        if (cyc !== 8 || data_out !== 16'hEC00) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d dout=%h, want 8 ec00", cyc, data_out);
        end
        @(posedge clk); #1;
        ready_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: vld=%b busy=%b, want 0 0", valid_out, busy);
        end
    endtask

    // Asynchronous reset in the middle of encoding, then a clean block.
    task automatic test_reset_mid();
        int vld_seen;
        valid_in = 1'b1; data_in = 8'hFF; ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || data_out === 16'h0000) begin
            errors++;
            $display("FAIL rstmid_pre: busy=%b dout=%h, want 1 and nonzero", busy, data_out);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async: rdy=%b vld=%b busy=%b dout=%h, want 1 0 0 0000",
                     ready_out, valid_out, busy, data_out);
        end
        vld_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b0) vld_seen++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (valid_out !== 1'b0) vld_seen++;
        end
        ready_in = 1'b0;
        checks++;
        if (vld_seen !== 0) begin
            errors++;
            $display("FAIL rstmid_no_valid: valid_out seen %0d cycles, want 0", vld_seen);
        end
        test_encode(8'hFF, 16'hDAAA, "rstmid_ff");
    endtask

`ifdef CONV_ENCODER_ERR_INJECT_EN
    task automatic test_err_inject();
        err_mask = 16'h0100;
        test_encode(8'hB0, 16'hE070, "errinj");
        err_mask = 16'h0000;
        test_encode(8'hB0, 16'hE170, "errinj_clear");
    endtask
`endif

    initial begin
        test_reset();
        test_encode(8'hB0, 16'hE170, "enc_b0");
        test_encode(8'h00, 16'h0000, "enc_00");
        test_encode(8'hFF, 16'hDAAA, "enc_ff");
        test_encode(8'h80, 16'hEC00, "enc_80");
        test_hold_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef CONV_ENCODER_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
